vga_sync_decoder: RTL and testbench

- Receive-side companion to the VGA sync generator.
- Consumes H/V sync pulses running on the same pixel clock and regenerates pixel column/row coordinates, line/frame start strobes and an active-video flag.
- Checks line and frame timing, and reports lock and sync errors.
- Used to drive pattern/overlay logic downstream of an incoming sync pair, and as a self-check monitor on the generator's output.

---
 rtl/vga_sync_decoder.sv | 144 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds column/row coordinates from an
// incoming H/V sync pair, checks line and frame lengths and tracks lock.
module vga_sync_decoder #(
    parameter int   TOTAL_COLS  = 800,
    parameter int   TOTAL_ROWS  = 525,
    parameter int   ACTIVE_COLS = 640,
    parameter int   ACTIVE_ROWS = 480,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_LINES  = 4,
    parameter int   CW          = 10
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          i_HSync,
    input  logic          i_VSync,
    output logic [CW-1:0] o_Col,
    output logic [CW-1:0] o_Row,
    output logic          o_Line_Start,
    output logic          o_Frame_Start,
    output logic          o_Active,
    output logic          o_Locked,
    output logic          o_Sync_Err
);

    localparam int LW = $clog2(2*TOTAL_COLS + 1);
    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam logic [LW-1:0] LEN_SAT  = LW'(2*TOTAL_COLS);
    localparam logic [LW-1:0] LEN_LINE = LW'(TOTAL_COLS);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    logic          hs_q, vs_q;
    logic          he, ve;
    logic [CW-1:0] col_next, row_next;
    logic [LW-1:0] len_reg, len_next;
    logic [GW-1:0] good_reg, good_next;
    logic [1:0]    state_reg, state_next;
    logic          err_next;
    logic          line_bad, frame_bad, len_sat;

    always_comb begin
        he = (i_HSync == SYNC_POL) && (hs_q != SYNC_POL);
        ve = (i_VSync == SYNC_POL) && (vs_q != SYNC_POL);

        if (he || (o_Col == CW'(TOTAL_COLS - 1)))
            col_next = '0;
        else
            col_next = o_Col + CW'(1);

        // VSync wins over a coincident HSync so the frame starts on row 0
        if (ve)
            row_next = '0;
        else if (he)
            row_next = (o_Row == CW'(TOTAL_ROWS - 1)) ? '0 : o_Row + CW'(1);
        else
            row_next = o_Row;

        if (he)
            len_next = LW'(1);
        else if (len_reg == LEN_SAT)
            len_next = len_reg;
        else
            len_next = len_reg + LW'(1);

        line_bad  = he && (len_reg != LEN_LINE);
        frame_bad = ve && (o_Row != CW'(TOTAL_ROWS - 1));
        len_sat   = !he && (len_reg == LEN_SAT);
    end

    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        err_next   = 1'b0;
        case (state_reg)
            ST_UNLOCKED: begin
                if (he) begin
                    state_next = ST_ACQUIRE;
                    good_next  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (line_bad || frame_bad) begin
                    err_next  = 1'b1;
                    good_next = '0;
                end else if (he) begin
                    if (good_reg == GW'(LOCK_LINES - 1)) begin
                        state_next = ST_LOCKED;
                        good_next  = '0;
                    end else begin
                        good_next = good_reg + GW'(1);
                    end
                end else if (len_sat) begin
                    state_next = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (line_bad || frame_bad) begin
                    err_next   = 1'b1;
                    state_next = ST_ACQUIRE;
                    good_next  = '0;
                end else if (len_sat) begin
                    state_next = ST_UNLOCKED;
                end
            end
            default: begin
                state_next = ST_UNLOCKED;
                good_next  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            o_Col         <= '0;
            o_Row         <= '0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Active      <= 1'b0;
            o_Locked      <= 1'b0;
            o_Sync_Err    <= 1'b0;
            len_reg       <= '0;
            good_reg      <= '0;
            state_reg     <= ST_UNLOCKED;
        end else begin
            hs_q          <= i_HSync;
            vs_q          <= i_VSync;
            o_Col         <= col_next;
            o_Row         <= row_next;
            o_Line_Start  <= he;
            o_Frame_Start <= ve;
            o_Active      <= (col_next < CW'(ACTIVE_COLS)) && (row_next < CW'(ACTIVE_ROWS));
            o_Locked      <= (state_reg == ST_LOCKED);
            o_Sync_Err    <= err_next;
            len_reg       <= len_next;
            good_reg      <= good_next;
            state_reg     <= state_next;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized scoreboard bench for vga_sync_decoder on a scaled-down raster.
module tb_vga_sync_decoder;

    localparam int TC = 40;
    localparam int TR = 12;
    localparam int AC = 32;
    localparam int AR = 9;
    localparam int LL = 4;
    localparam int CW = 10;
    localparam int HW = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          hs = 1'b1;
    logic          vs = 1'b1;
    logic [CW-1:0] o_Col, o_Row;
    logic          o_Line_Start, o_Frame_Start, o_Active, o_Locked, o_Sync_Err;

    typedef struct packed {
        logic [CW-1:0] col;
        logic [CW-1:0] row;
        logic          ls;
        logic          fs;
        logic          act;
        logic          lk;
        logic          err;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // reference model state, in terms of edge events
    int m_n, m_last_he, m_col_base, m_rows, m_st, m_good;
    logic m_phs, m_pvs;

    vga_sync_decoder #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .SYNC_POL(1'b0), .LOCK_LINES(LL), .CW(CW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .i_HSync(hs), .i_VSync(vs),
        .o_Col(o_Col), .o_Row(o_Row), .o_Line_Start(o_Line_Start),
        .o_Frame_Start(o_Frame_Start), .o_Active(o_Active),
        .o_Locked(o_Locked), .o_Sync_Err(o_Sync_Err)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_n = 0; m_last_he = 0; m_col_base = 0; m_rows = 0;
        m_st = 0; m_good = 0; m_phs = 1'b1; m_pvs = 1'b1;
    endtask

    // state codes: 0 unlocked, 1 acquiring, 2 locked
    task automatic model_step(input logic h, input logic v);
        exp_t e;
        bit he, ve, line_bad, frame_bad, sat;
        int k, col, row;
        he = (h == 1'b0) && (m_phs != 1'b0);
        ve = (v == 1'b0) && (m_pvs != 1'b0);
        m_phs = h; m_pvs = v;
        m_n++;
        k = m_n - m_last_he;
        line_bad  = he && (k != TC);
        frame_bad = ve && ((m_rows % TR) != TR - 1);
        sat       = !he && (k >= 2*TC);
        e.lk  = (m_st == 2);
        e.err = 1'b0;
        if (m_st == 0) begin
            if (he) begin m_st = 1; m_good = 0; end
        end else if (line_bad || frame_bad) begin
            e.err = 1'b1; m_good = 0; m_st = 1;
        end else if (m_st == 1 && he) begin
            m_good++;
            if (m_good == LL) begin m_st = 2; m_good = 0; end
        end else if (sat) begin
            m_st = 0;
        end
        if (he) begin m_col_base = m_n; m_last_he = m_n; end
        if (ve) m_rows = 0;
        else if (he) m_rows++;
        col = (m_n - m_col_base) % TC;
        row = m_rows % TR;
        e.col = CW'(col);
        e.row = CW'(row);
        e.act = (col < AC) && (row < AR);
        e.ls  = he;
        e.fs  = ve;
        q.push_back(e);
    endtask

    task automatic cycle(input logic h, input logic v);
        @(negedge CLK);
        hs = h; vs = v;
        if (RST_N) model_step(h, v);
    endtask

    task automatic hold(input int n, input logic h, input logic v);
        for (int i = 0; i < n; i++) cycle(h, v);
    endtask

    task automatic line(input int len, input logic v);
        for (int c = 0; c < len; c++) cycle((c < HW) ? 1'b0 : 1'b1, v);
    endtask

    task automatic frame(input int nlines, input int bad_row, input int bad_len);
        for (int r = 0; r < nlines; r++)
            line((r == bad_row) ? bad_len : TC, (r < 2) ? 1'b0 : 1'b1);
    endtask

    task automatic do_reset(input int n);
        @(posedge CLK);
        #2;
        RST_N = 1'b0; hs = 1'b1; vs = 1'b1;
        #1;
        vectors++;
        if ({o_Col, o_Row, o_Line_Start, o_Frame_Start, o_Active, o_Locked, o_Sync_Err} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: col=%0d row=%0d ls=%b fs=%b act=%b lk=%b err=%b, required all zero",
                     o_Col, o_Row, o_Line_Start, o_Frame_Start, o_Active, o_Locked, o_Sync_Err);
        end
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        model_step(1'b1, 1'b1);
    endtask

    always @(posedge CLK) begin
        exp_t e, a;
        #1;
        if (RST_N) begin
            a = '{col: o_Col, row: o_Row, ls: o_Line_Start, fs: o_Frame_Start,
                  act: o_Active, lk: o_Locked, err: o_Sync_Err};
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty at %0t: no expected entry for this cycle", $time);
            end else begin
                e = q.pop_front();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle %0t: got col=%0d row=%0d ls=%b fs=%b act=%b lk=%b err=%b, required col=%0d row=%0d ls=%b fs=%b act=%b lk=%b err=%b",
                             $time, a.col, a.row, a.ls, a.fs, a.act, a.lk, a.err,
                             e.col, e.row, e.ls, e.fs, e.act, e.lk, e.err);
                end
            end
        end
    end

    initial begin
        int nl, br, bl;
        do_reset(3);

        // clean stream: lock after unchecked edge plus four good lines
        repeat (3) frame(TR, -1, 0);
        frame(TR, 5, TC - 1);
        repeat (2) frame(TR, -1, 0);
        frame(6, -1, 0);
        repeat (2) frame(TR, -1, 0);
        // long asserted HSync gives one edge only
        hold(TC + 20, 1'b0, 1'b1);
        hold(TC, 1'b1, 1'b1);
        repeat (2) frame(TR, -1, 0);
        // HSync dropout long enough to saturate the line counter
        hold(3*TC, 1'b1, 1'b1);
        repeat (2) frame(TR, -1, 0);

        for (int f = 0; f < 30; f++) begin
            nl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, TR + 2)) : TR;
            br = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            bl = $urandom_range(HW + 1, 2*TC + 5);
            frame(nl, br, bl);
            if ($urandom_range(0, 9) == 0) hold($urandom_range(TC, 3*TC), 1'b1, 1'b1);
        end

        frame(TR, -1, 0);
        hold($urandom_range(10, 5*TC), 1'b1, 1'b1);
        line(TC, 1'b1);
        do_reset($urandom_range(1, 5));
        repeat (3) frame(TR, -1, 0);

        hold(4, 1'b1, 1'b1);
        @(posedge CLK);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
